shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter DSIZE, default 16, data width.
REQ-002 SHALL have parameter OPSIZE, default 2, shift-op width.
REQ-003 SHALL have parameter CSIZE, default 4, shift-count width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port op_in  input  OPSIZE  shift op: 00 logical right, 01 logical left, 10 rotate right, 11 rotate left.
REQ-008 SHALL have port din  input  DSIZE  operand.
REQ-009 SHALL have port count  input  CSIZE  number of single-bit shifts, 0..2^CSIZE-1.
REQ-010 SHALL have port busy  output  1  high in SHIFT and DONE states.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port dout  output  DSIZE  result register.
REQ-013 SHALL have port shf_data_b  output  DSIZE  operand to the downstream one-bit shifter.
REQ-014 SHALL have port shf_op  output  OPSIZE  op to the one-bit shifter.
REQ-015 SHALL have port shf_f  input  DSIZE  one-bit shifter result (combinational return).

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-017 SHALL drive shf_data_b from internal work register wreg and shf_op from latched op register opr at all times.
REQ-018 IDLE with start=1 SHALL load wreg<=din, opr<=op_in, cnt<=count on that edge.
REQ-019 From IDLE with start=1: count!=0 -> SHIFT; count==0 -> DONE.
REQ-020 IDLE with start=0 SHALL remain IDLE, registers unchanged.
REQ-021 In SHIFT each edge SHALL do wreg<=shf_f, cnt<=cnt-1; when cnt==1 the next state SHALL be DONE, else SHIFT.
REQ-022 In DONE: done=1 for exactly that cycle; on the same edge that leaves DONE, dout<=wreg is NOT used -- dout SHALL be loaded with the final wreg value on entry to DONE (dout valid while done=1).
REQ-023 DONE SHALL always return to IDLE on the next edge.
REQ-024 Latency: start sampled at edge E0 -> done high during the cycle after edge E(count); count=0 -> done high in cycle after E0 with dout=din.
REQ-025 start while busy=1 SHALL be ignored (no reload, no queueing).
REQ-026 start high in the DONE cycle SHALL be ignored; a new start is accepted only once back in IDLE (back-to-back throughput: one operation per count+2 cycles).
REQ-027 dout SHALL hold its value until the next entry to DONE.
REQ-028 Logical shifts SHALL fill with 0; rotates SHALL wrap the exiting bit; shifts by count>=DSIZE (logical) SHALL yield 0.
REQ-029 done and busy SHALL be registered (decoded from state register only, no combinational path from start).

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=IDLE, wreg=0, opr=0, cnt=0, dout=0, busy=0, done=0.
REQ-031 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no done pulse; after release the block SHALL accept start in the first cycle.

Verification
REQ-032 din=0x8001, op_in=11, count=1, start pulse -> done in cycle after E1, dout=0x0003.
REQ-033 din=0xF0F0, op_in=00, count=4 -> busy high 5 cycles, done one cycle after E4, dout=0x0F0F.
REQ-034 din=0x1234, any op, count=0 -> done in cycle after E0, dout=0x1234.
REQ-035 din=0x0001, op_in=10, count=15 -> dout=0x0002; second start with din=0xFFFF issued mid-operation ignored (dout unchanged by it).
REQ-036 din=0xFFFF, op_in=01, count=8, rst_n pulsed low after 3 shifts -> no done pulse, dout=0x0000, busy=0; next start processes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// Iterative shift sequencer: drives an external one-bit shifter once per cycle
// until the requested number of single-bit shifts has been applied.
module shift_sequencer #(
   parameter int DSIZE  = 16,
   parameter int OPSIZE = 2,
   parameter int CSIZE  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [OPSIZE-1:0] op_in,
   input  logic [DSIZE-1:0]  din,
   input  logic [CSIZE-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic [DSIZE-1:0]  dout,
   output logic [DSIZE-1:0]  shf_data_b,
   output logic [OPSIZE-1:0] shf_op,
   input  logic [DSIZE-1:0]  shf_f
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]        r_state;
   logic [DSIZE-1:0]  r_wreg;
   logic [OPSIZE-1:0] r_opr;
   logic [CSIZE-1:0]  r_cnt;
   logic [DSIZE-1:0]  r_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_wreg  <= '0;
         r_opr   <= '0;
         r_cnt   <= '0;
         r_dout  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_wreg <= din;
                  r_opr  <= op_in;
                  r_cnt  <= count;
                  if (count == '0) begin
                     r_state <= S_DONE;
                     r_dout  <= din;
                  end else begin
                     r_state <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               r_wreg <= shf_f;
               r_cnt  <= r_cnt - CSIZE'(1);
               // Result is captured on entry to DONE so dout is valid alongside the pulse
               if (r_cnt == CSIZE'(1)) begin
                  r_state <= S_DONE;
                  r_dout  <= shf_f;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy       = (r_state == S_SHIFT) || (r_state == S_DONE);
   assign done       = (r_state == S_DONE);
   assign dout       = r_dout;
   assign shf_data_b = r_wreg;
   assign shf_op     = r_opr;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: supplies a one-bit shifter and checks timing and
// results against an arithmetic reference for directed and random operations.
module tb_shift_sequencer;

   localparam int DSIZE  = 16;
   localparam int OPSIZE = 2;
   localparam int CSIZE  = 4;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [OPSIZE-1:0] op_in;
   logic [DSIZE-1:0]  din;
   logic [CSIZE-1:0]  count;
   logic              busy;
   logic              done;
   logic [DSIZE-1:0]  dout;
   logic [DSIZE-1:0]  shf_data_b;
   logic [OPSIZE-1:0] shf_op;
   logic [DSIZE-1:0]  shf_f;

   int total = 0;
   int bad   = 0;

   shift_sequencer #(.DSIZE(DSIZE), .OPSIZE(OPSIZE), .CSIZE(CSIZE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .op_in      (op_in),
      .din        (din),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .dout       (dout),
      .shf_data_b (shf_data_b),
      .shf_op     (shf_op),
      .shf_f      (shf_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream one-bit shifter
   always_comb begin
      case (shf_op)
         2'b00:   shf_f = shf_data_b >> 1;
         2'b01:   shf_f = shf_data_b << 1;
         2'b10:   shf_f = {shf_data_b[0], shf_data_b[DSIZE-1:1]};
         default: shf_f = {shf_data_b[DSIZE-2:0], shf_data_b[DSIZE-1]};
      endcase
   end

   function automatic logic [DSIZE-1:0] ref_result(input logic [DSIZE-1:0] d,
                                                   input logic [1:0] op, input int n);
      longint unsigned x, r;
      x = longint'(d);
      case (op)
         2'b00: r = (n >= DSIZE) ? 0 : (x >> n);
         2'b01: r = (n >= DSIZE) ? 0 : (x << n);
         2'b10: r = (x >> (n % DSIZE)) | (x << (DSIZE - (n % DSIZE)));
         default: r = (x << (n % DSIZE)) | (x >> (DSIZE - (n % DSIZE)));
      endcase
      return DSIZE'(r & ((64'd1 << DSIZE) - 1));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One operation; optional junk start mid-operation and a start held in the DONE cycle.
   task automatic run_op(input logic [DSIZE-1:0] d, input logic [1:0] op,
                         input int n, input bit inject, input bit start_in_done);
      logic [DSIZE-1:0] exp;
      exp   = ref_result(d, op, n);
      din   = d;
      op_in = op;
      count = CSIZE'(n);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_E0", busy, 1);
      check("done_after_E0", done, (n == 0));
      if (inject) begin
         din   = ~d;
         op_in = ~op;
         count = CSIZE'(n + 3);
         start = 1'b1;
      end
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         check("busy_shift", busy, 1);
         check("done_timing", done, (k == n));
      end
      check("dout_result", dout, exp);
      if (start_in_done) begin
         din   = $urandom;
         count = CSIZE'(0);
         start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      @(posedge clk); #1;
      check("idle_stays", busy, 0);
      check("dout_hold", dout, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op_in = '0;
      din   = '0;
      count = '0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dout", dout, 0);
      check("rst_shf_b", shf_data_b, 0);
      check("rst_shf_op", shf_op, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(16'h8001, 2'b11, 1, 0, 0);
      check("v032", dout, 16'h0003);
      run_op(16'hF0F0, 2'b00, 4, 0, 0);
      check("v033", dout, 16'h0F0F);
      run_op(16'h1234, 2'b10, 0, 0, 0);
      check("v034", dout, 16'h1234);
      run_op(16'h0001, 2'b10, 15, 1, 0);
      check("v035", dout, 16'h0002);
      run_op(16'hABCD, 2'b01, 3, 0, 1);
      run_op(16'h5A5A, 2'b00, 0, 1, 1);

      // Reset mid-SHIFT after three shifts
      din   = 16'hFFFF;
      op_in = 2'b01;
      count = CSIZE'(8);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 3; k++) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_dout", dout, 0);
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
      rst_n = 1'b1;
      run_op(16'hFFFF, 2'b01, 8, 0, 0);
      check("after_abort", dout, 16'hFF00);

      // Reset while in DONE
      din   = 16'h00FF;
      op_in = 2'b00;
      count = CSIZE'(0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_before_rst", done, 1);
      rst_n = 1'b0;
      #1;
      check("rst_in_done", done, 0);
      check("rst_in_done_dout", dout, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 30; i++) begin
         run_op(DSIZE'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
